// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch PC unit: pc_src encodings, fetch FSM states
// and the default boot/exception vectors.
package pc_fetch_unit_pkg;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_J   = 2'b01;
    localparam logic [1:0] PC_SRC_BR  = 2'b10;
    localparam logic [1:0] PC_SRC_JR  = 2'b11;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target, link address and misalignment detection
// from the decode-stage control-flow fields.
module pc_target_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    output logic [31:0] target,
    output logic [31:0] link_addr,
    output logic        is_redirect,
    output logic        misaligned
);

    logic [31:0] seq;
    logic [31:0] br_off;

    assign seq       = pc_d + 32'd4;
    assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};
    assign link_addr = pc_d + 32'd8;

    always_comb begin
        target = seq;
        case (pc_src)
            PC_SRC_J:  target = {seq[31:28], instr_index, 2'b00};
            PC_SRC_BR: target = seq + br_off;
            PC_SRC_JR: target = rs_val;
            default:   target = seq;
        endcase
    end

    assign is_redirect = (pc_src != PC_SRC_SEQ);
    assign misaligned  = is_redirect && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC owner: issues instruction fetches over a valid/ready handshake and
// applies branch redirects after the one-instruction delay slot.
//
// state    | meaning
// ST_BOOT  | first cycle after reset, no request
// ST_ISSUE | request pc unless stalled
// ST_WAIT  | request outstanding, address held until imem_ready
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_valid,
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] link_addr,
    output logic        addr_err
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic [31:0] pc;
    logic        pending_valid;
    logic [31:0] pending_target;
    logic        slot_armed;

    logic [31:0] calc_target;
    logic        calc_redirect;
    logic        calc_misaligned;

    logic        take;
    logic [31:0] accept_target;
    logic        complete;
    logic        slot_now;
    logic [31:0] redir_target;

    pc_target_calc u_target_calc (
        .pc_src      (pc_src),
        .pc_d        (pc_d),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .target      (calc_target),
        .link_addr   (link_addr),
        .is_redirect (calc_redirect),
        .misaligned  (calc_misaligned)
    );

    // A redirect arriving while one is already pending is dropped.
    assign take          = redir_valid && calc_redirect && !pending_valid;
    assign accept_target = calc_misaligned ? EXC_VECTOR : calc_target;
    assign complete      = imem_req && imem_ready;
    // Same-edge acceptance counts as armed so the coinciding completion is the slot.
    assign slot_now      = slot_armed || take;
    assign redir_target  = pending_valid ? pending_target : accept_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (!stall) begin
                    state_nxt = imem_ready ? ST_ISSUE : ST_WAIT;
                end
            end
            ST_WAIT:  state_nxt = imem_ready ? ST_ISSUE : ST_WAIT;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        case (state)
            ST_ISSUE: imem_req = !stall;
            ST_WAIT:  imem_req = 1'b1;
            default:  imem_req = 1'b0;
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_VECTOR;
            pending_valid  <= 1'b0;
            pending_target <= 32'd0;
            slot_armed     <= 1'b0;
        end else if (complete && slot_now) begin
            pc            <= redir_target;
            pending_valid <= 1'b0;
            slot_armed    <= 1'b0;
        end else begin
            if (complete) begin
                pc <= pc + 32'd4;
            end
            if (take) begin
                pending_valid  <= 1'b1;
                pending_target <= accept_target;
                slot_armed     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_pc    <= 32'd0;
            addr_err    <= 1'b0;
        end else begin
            fetch_valid <= complete;
            if (complete) begin
                fetch_pc <= pc;
            end
            addr_err <= take && calc_misaligned;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot sequence, redirects with delay slot,
// misaligned jr, wait states with stall, and reset during an outstanding fetch.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redir_valid;
    logic [1:0]  pc_src;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] link_addr;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redir_valid (redir_valid),
        .pc_src      (pc_src),
        .pc_d        (pc_d),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .link_addr   (link_addr),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_redirect(input logic [1:0] src, input logic [31:0] pcd,
                                  input logic [15:0] imm, input logic [25:0] idx,
                                  input logic [31:0] rs);
        redir_valid = 1'b1;
        pc_src      = src;
        pc_d        = pcd;
        imm16       = imm;
        instr_index = idx;
        rs_val      = rs;
    endtask

    task automatic clear_redirect();
        redir_valid = 1'b0;
        pc_src      = 2'b00;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fvalid got %b want 0", fetch_valid); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_aerr got %b want 0", addr_err); end
        checks++; if (imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL rst_addr got %h want bfc00000", imem_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b want 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL issue_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL first_addr got %h want bfc00000", imem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL first_fvalid got %b want 0", fetch_valid); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hBFC00000) begin errors++; $display("FAIL seq0 got %b/%h want 1/bfc00000", fetch_valid, fetch_pc); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hBFC00004) begin errors++; $display("FAIL seq1 got %b/%h want 1/bfc00004", fetch_valid, fetch_pc); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hBFC00008) begin errors++; $display("FAIL seq2 got %b/%h want 1/bfc00008", fetch_valid, fetch_pc); end
        checks++; if (imem_addr !== 32'hBFC0000C) begin errors++; $display("FAIL seq_addr got %h want bfc0000c", imem_addr); end
    endtask

    // jr to 00400014 so the fetch stream sits on the branch's delay slot.
    task automatic test_branch();
        drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h00400014);
        step();
        checks++; if (fetch_pc !== 32'hBFC0000C) begin errors++; $display("FAIL jr_slot got %h want bfc0000c", fetch_pc); end
        checks++; if (imem_addr !== 32'h00400014) begin errors++; $display("FAIL jr_target got %h want 00400014", imem_addr); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL jr_aerr got %b want 0", addr_err); end
        drive_redirect(2'b10, 32'h00400010, 16'hFFFC, 26'h0, 32'h0);
        #1;
        checks++; if (link_addr !== 32'h00400018) begin errors++; $display("FAIL link got %h want 00400018", link_addr); end
        step();
        clear_redirect();
        checks++; if (fetch_pc !== 32'h00400014) begin errors++; $display("FAIL br_slot got %h want 00400014", fetch_pc); end
        checks++; if (imem_addr !== 32'h00400004) begin errors++; $display("FAIL br_addr got %h want 00400004", imem_addr); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h00400004) begin errors++; $display("FAIL br_target got %b/%h want 1/00400004", fetch_valid, fetch_pc); end
    endtask

    task automatic test_jump();
        drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h00400024);
        step();
        checks++; if (imem_addr !== 32'h00400024) begin errors++; $display("FAIL j_setup got %h want 00400024", imem_addr); end
        drive_redirect(2'b01, 32'h00400020, 16'h0, 26'h0000040, 32'h0);
        step();
        clear_redirect();
        checks++; if (fetch_pc !== 32'h00400024) begin errors++; $display("FAIL j_slot got %h want 00400024", fetch_pc); end
        checks++; if (imem_addr !== 32'h00000100) begin errors++; $display("FAIL j_addr got %h want 00000100", imem_addr); end
        step();
        checks++; if (fetch_pc !== 32'h00000100) begin errors++; $display("FAIL j_target got %h want 00000100", fetch_pc); end
    endtask

    task automatic test_misaligned();
        drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h00400102);
        step();
        clear_redirect();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b want 1", addr_err); end
        checks++; if (fetch_pc !== 32'h00000104) begin errors++; $display("FAIL mis_slot got %h want 00000104", fetch_pc); end
        checks++; if (imem_addr !== 32'hBFC00380) begin errors++; $display("FAIL mis_addr got %h want bfc00380", imem_addr); end
        step();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mis_once got %b want 0", addr_err); end
        checks++; if (fetch_pc !== 32'hBFC00380) begin errors++; $display("FAIL mis_exc got %h want bfc00380", fetch_pc); end
    endtask

    task automatic test_wait_stall();
        imem_ready = 1'b0;
        stall      = 1'b0;
        step();
        checks++; if (imem_addr !== 32'hBFC00384 || imem_req !== 1'b1) begin errors++; $display("FAIL w1 got %h/%b want bfc00384/1", imem_addr, imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL w1_fv got %b want 0", fetch_valid); end
        stall = 1'b1;
        drive_redirect(2'b01, 32'h00400020, 16'h0, 26'h0000040, 32'h0);
        step();
        clear_redirect();
        checks++; if (imem_addr !== 32'hBFC00384 || imem_req !== 1'b1) begin errors++; $display("FAIL w2 got %h/%b want bfc00384/1", imem_addr, imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL w2_fv got %b want 0", fetch_valid); end
        stall = 1'b0;
        step();
        checks++; if (imem_addr !== 32'hBFC00384 || fetch_valid !== 1'b0) begin errors++; $display("FAIL w3 got %h/%b want bfc00384/0", imem_addr, fetch_valid); end
        imem_ready = 1'b1;
        stall      = 1'b1;
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hBFC00384) begin errors++; $display("FAIL w_done got %b/%h want 1/bfc00384", fetch_valid, fetch_pc); end
        checks++; if (imem_addr !== 32'h00000100) begin errors++; $display("FAIL w_redir got %h want 00000100", imem_addr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", imem_req); end
        step();
        checks++; if (fetch_valid !== 1'b0 || imem_addr !== 32'h00000100) begin errors++; $display("FAIL stall_hold got %b/%h want 0/00000100", fetch_valid, imem_addr); end
        stall = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h00000100) begin errors++; $display("FAIL w_target got %b/%h want 1/00000100", fetch_valid, fetch_pc); end
    endtask

    task automatic test_reset_mid_wait();
        imem_ready = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_req got %b want 1", imem_req); end
        drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h00400040);
        step();
        clear_redirect();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL rw_pc got %h want bfc00000", imem_addr); end
        #2;
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL rw_first got %b/%h want 1/bfc00000", imem_req, imem_addr); end
        step();
        checks++; if (fetch_pc !== 32'hBFC00000) begin errors++; $display("FAIL rw_f0 got %h want bfc00000", fetch_pc); end
        step();
        checks++; if (fetch_pc !== 32'hBFC00004) begin errors++; $display("FAIL rw_f1 got %h want bfc00004", fetch_pc); end
        step();
        checks++; if (fetch_pc !== 32'hBFC00008) begin errors++; $display("FAIL rw_f2 got %h want bfc00008", fetch_pc); end
    endtask

    initial begin
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        pc_src      = 2'b00;
        pc_d        = 32'h0;
        imm16       = 16'h0;
        instr_index = 26'h0;
        rs_val      = 32'h0;
        stall       = 1'b0;
        imem_ready  = 1'b1;
        test_reset();
        test_branch();
        test_jump();
        test_misaligned();
        test_wait_stall();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
